// File: rtl/imem_boot_loader.sv
// Boot-time instruction memory loader.
// Accepts a length-prefixed byte stream, writes the payload into the instruction
// memory one byte per transfer, verifies an 8-bit additive checksum, and releases
// the CPU reset only after a verified load.
module imem_boot_loader #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StLoad,
        StCheck,
        StDone,
        StErr
    } state_t;

    localparam logic [15:0] MEM_LIMIT = 16'(MEM_BYTES);

    state_t      state_q;
    logic [7:0]  len_hi_q;
    logic [15:0] len_q;
    logic [15:0] cnt_q;
    logic [7:0]  sum_q;

    logic        xfer;
    logic [15:0] len_word;
    logic [15:0] cnt_next;

    // Handshake and status are pure functions of the current state.
    assign in_ready = (state_q == StLenHi) || (state_q == StLenLo) ||
                      (state_q == StLoad)  || (state_q == StCheck);
    assign busy     = in_ready;

    assign xfer     = in_valid & in_ready;
    // Full payload length as seen during the LEN_LO transfer.
    assign len_word = {len_hi_q, in_byte};
    assign cnt_next = cnt_q + 16'd1;

    // Session FSM with registered memory-write and completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            len_hi_q  <= 8'h00;
            len_q     <= 16'h0000;
            cnt_q     <= 16'h0000;
            sum_q     <= 8'h00;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse per accepted payload byte.
            mem_we <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StLenHi;
                        cnt_q   <= 16'h0000;
                        sum_q   <= 8'h00;
                        done    <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                StLenHi: begin
                    if (xfer) begin
                        len_hi_q <= in_byte;
                        state_q  <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (xfer) begin
                        len_q <= len_word;
                        if ((len_word > MEM_LIMIT) || (len_word[1:0] != 2'b00)) begin
                            state_q <= StErr;
                            err     <= 1'b1;
                        end else if (len_word == 16'h0000) begin
                            state_q <= StCheck;
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (xfer) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= cnt_q[ADDR_W-1:0];
                        mem_wdata <= in_byte;
                        sum_q     <= sum_q + in_byte;
                        cnt_q     <= cnt_next;
                        if (cnt_next == len_q) begin
                            state_q <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (xfer) begin
                        if (in_byte == sum_q) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end else begin
                            state_q <= StErr;
                            err     <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (start) begin
                        state_q <= StLenHi;
                        cnt_q   <= 16'h0000;
                        sum_q   <= 8'h00;
                        done    <= 1'b0;
                        cpu_rst <= 1'b1;
                    end
                end
                StErr: begin
                    if (start) begin
                        state_q <= StLenHi;
                        cnt_q   <= 16'h0000;
                        sum_q   <= 8'h00;
                        err     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader.
module tb_imem_boot_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_rst;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    // Write log filled by the monitor below.
    int         wr_cnt = 0;
    logic [9:0] wr_addr_log [0:4095];
    logic [7:0] wr_data_log [0:4095];

    imem_boot_loader #(
        .MEM_BYTES(1024),
        .ADDR_W   (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // mem_we is a one-cycle registered pulse, so each write is seen once here.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_cnt < 4096) begin
                wr_addr_log[wr_cnt] = mem_addr;
                wr_data_log[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_mem_we"},    32'(mem_we),    32'h0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
        chk({tag, "_cpu_rst"},   32'(cpu_rst),   32'h1);
        chk({tag, "_busy"},      32'(busy),      32'h0);
        chk({tag, "_done"},      32'(done),      32'h0);
        chk({tag, "_err"},       32'(err),       32'h0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'h0);
    endtask

    // Sends a 4-byte image back to back, checking each registered write.
    task automatic stream4(input string tag, input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3, input logic [7:0] cs);
        logic [7:0] p [4];
        p[0] = p0;
        p[1] = p1;
        p[2] = p2;
        p[3] = p3;
        send(8'h00);
        send(8'h04);
        chk({tag, "_load_busy"}, 32'(busy), 32'h1);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_byte = p[i];
            tick();
            chk({tag, "_we"},    32'(mem_we),    32'h1);
            chk({tag, "_addr"},  32'(mem_addr),  32'(i));
            chk({tag, "_wdata"}, 32'(mem_wdata), 32'(p[i]));
        end
        in_byte = cs;
        tick();
        in_valid = 1'b0;
        chk({tag, "_we_after"}, 32'(mem_we), 32'h0);
    endtask

    initial begin
        int         base;
        int         bad;
        int         gap;
        logic [7:0] sum;
        logic [7:0] b;

        rst      = 1'b1;
        start    = 1'b0;
        in_byte  = 8'h00;
        in_valid = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Good 4-byte image.
        pulse_start();
        chk("start_busy",  32'(busy),     32'h1);
        chk("start_ready", 32'(in_ready), 32'h1);
        base = wr_cnt;
        stream4("good", 8'h00, 8'h10, 8'h03, 8'h13, 8'h26);
        chk("good_done",    32'(done),    32'h1);
        chk("good_cpu_rst", 32'(cpu_rst), 32'h0);
        chk("good_err",     32'(err),     32'h0);
        chk("good_busy",    32'(busy),    32'h0);
        chk("good_nwr",     32'(wr_cnt - base), 32'd4);

        // Restart from DONE re-asserts CPU reset on the next cycle.
        pulse_start();
        chk("restart_done",    32'(done),    32'h0);
        chk("restart_cpu_rst", 32'(cpu_rst), 32'h1);

        // Bad checksum.
        stream4("badcs", 8'h00, 8'h10, 8'h03, 8'h13, 8'h27);
        chk("badcs_err",     32'(err),     32'h1);
        chk("badcs_done",    32'(done),    32'h0);
        chk("badcs_cpu_rst", 32'(cpu_rst), 32'h1);
        pulse_start();
        chk("errclr_err", 32'(err), 32'h0);
        stream4("reload", 8'h00, 8'h10, 8'h03, 8'h13, 8'h26);
        chk("reload_done",    32'(done),    32'h1);
        chk("reload_cpu_rst", 32'(cpu_rst), 32'h0);

        // Length too large.
        pulse_start();
        base = wr_cnt;
        send(8'h04);
        send(8'h01);
        chk("len1025_err",   32'(err),      32'h1);
        chk("len1025_ready", 32'(in_ready), 32'h0);
        send(8'h55);
        chk("len1025_nwr",   32'(wr_cnt - base), 32'd0);

        // Length not a multiple of four.
        pulse_start();
        send(8'h00);
        send(8'h06);
        chk("len6_err", 32'(err), 32'h1);
        send(8'h55);
        chk("len6_nwr", 32'(wr_cnt - base), 32'd0);

        // Zero-length image.
        pulse_start();
        send(8'h00);
        send(8'h00);
        send(8'h00);
        chk("len0_done",    32'(done),    32'h1);
        chk("len0_cpu_rst", 32'(cpu_rst), 32'h0);
        pulse_start();
        send(8'h00);
        send(8'h00);
        send(8'h01);
        chk("len0_bad_err", 32'(err), 32'h1);
        chk("len0_nwr",     32'(wr_cnt - base), 32'd0);

        // Full 1024-byte image with random gaps and a stray start mid-load.
        pulse_start();
        base = wr_cnt;
        sum  = 8'h00;
        send(8'h04);
        send(8'h00);
        for (int k = 0; k < 1024; k++) begin
            gap = int'($urandom_range(2, 0));
            for (int g = 0; g < gap; g++) tick();
            if (k == 500) begin
                pulse_start();
                chk("midstart_busy", 32'(busy), 32'h1);
            end
            b   = 8'(k * 7 + 3);
            sum = sum + b;
            send(b);
        end
        send(sum);
        tick();
        chk("full_done", 32'(done), 32'h1);
        chk("full_nwr",  32'(wr_cnt - base), 32'd1024);
        bad = 0;
        for (int k = 0; k < 1024; k++) begin
            if (wr_addr_log[base + k] !== 10'(k)) bad++;
            if (wr_data_log[base + k] !== 8'(k * 7 + 3)) bad++;
        end
        chk("full_order", 32'(bad), 32'd0);

        // Reset in the middle of LOAD.
        pulse_start();
        send(8'h00);
        send(8'h08);
        for (int k = 0; k < 5; k++) send(8'(8'hA0 + k));
        chk("midrst_we", 32'(mem_we), 32'h1);
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0;
        tick();
        pulse_start();
        base = wr_cnt;
        stream4("fresh", 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
        chk("fresh_done",  32'(done), 32'h1);
        chk("fresh_addr0", 32'(wr_addr_log[base]), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
